// File: rtl/uart_tx_engine.sv
// uart_tx_engine: buffered async serial transmitter. Bytes written by the
// processor are queued in a small FIFO and sent as start / 7|8 data bits
// (LSB first) / optional parity / 1|2 stop bits at a programmable period.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   SET_BR     strobe: CONFIG_IN[15:0] -> bit period (CLK cycles, min 2)
//   SET_MODE   strobe: CONFIG_IN[3:0]  -> mode
//                [1:0] parity 00/11 none, 01 even, 10 odd
//                [2]   two stop bits
//                [3]   seven data bits
//   CONFIG_IN  configuration word
//   WRITE_DATA strobe: push DATA_IN into the FIFO
//   DATA_IN    byte to send
//   TX         serial line, idle high
//   BUSY       frame in flight or FIFO non-empty (lags state by a cycle)
//   FULL       FIFO holds FIFO_DEPTH bytes
//   OVERFLOW   sticky: a write hit a full FIFO
//   TX_DONE    one-cycle pulse when the final stop bit ends
//
// Build option: define UART_TX_PARITY_EN to include parity generation.
// Without it mode[1:0] is ignored and frames never carry a parity bit.

module uart_tx_engine #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SET_BR,
  input  logic        SET_MODE,
  input  logic [31:0] CONFIG_IN,
  input  logic        WRITE_DATA,
  input  logic [7:0]  DATA_IN,
  output logic        TX,
  output logic        BUSY,
  output logic        FULL,
  output logic        OVERFLOW,
  output logic        TX_DONE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // configuration (live values, sampled at frame start)
  logic [15:0] div_q;
  logic [3:0]  mode_q;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ovf_q;

  // frame engine
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] fdiv_q;
  logic [3:0]  fmode_q;
  logic [7:0]  shift_q;
  logic [2:0]  idx_q;
  logic        stop2_q;
  logic        tx_q;
  logic        done_q;
  logic        busy_q;

  logic        full;
  logic        push;
  logic        pop;
  logic        bit_end;
  logic        last_stop;
  logic [15:0] div_eff;
  logic [7:0]  head;
  logic [2:0]  last_idx;

  logic unused_cfg;
  assign unused_cfg = ^CONFIG_IN[31:16];

  assign full    = (count_q == DEPTH_C);
  assign push    = WRITE_DATA & ~full;
  assign bit_end = (cnt_q == 16'd0);
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;
  assign head    = mem_q[rd_ptr_q];

  assign last_idx = fmode_q[3] ? 3'd6 : 3'd7;

  // final stop bit is ending this cycle
  assign last_stop = (state_q == S_STOP)
                   & bit_end
                   & (~fmode_q[2] | stop2_q);

  // a new frame starts from idle or straight
  // out of the last stop bit (no idle gap)
  assign pop = (count_q != '0)
             & ((state_q == S_IDLE) | last_stop);

`ifdef UART_TX_PARITY_EN
  logic       par_q;
  logic       par_d;
  logic       has_par;
  logic [7:0] head_m;

  // parity covers only the bits actually sent
  assign head_m  = mode_q[3] ? {1'b0, head[6:0]} : head;
  assign par_d   = (^head_m) ^ (mode_q[1:0] == 2'b10);
  assign has_par = (fmode_q[1:0] == 2'b01)
                 | (fmode_q[1:0] == 2'b10);
`else
  logic unused_mode;
  assign unused_mode = ^fmode_q[1:0];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q  <= DEFAULT_DIV;
      mode_q <= '0;
    end else begin
      if (SET_BR) begin
        div_q <= CONFIG_IN[15:0];
      end
      if (SET_MODE) begin
        mode_q <= CONFIG_IN[3:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (WRITE_DATA & full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      fdiv_q  <= 16'd2;
      fmode_q <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      stop2_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= last_stop;
      busy_q <= (state_q != S_IDLE) | (count_q != '0);
      if (pop) begin
        // latch config so mid-frame strobes
        // only affect the following frame
        state_q <= S_START;
        tx_q    <= 1'b0;
        cnt_q   <= div_eff - 16'd1;
        fdiv_q  <= div_eff;
        fmode_q <= mode_q;
        shift_q <= head;
        idx_q   <= '0;
        stop2_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
      end else if ((state_q != S_IDLE) & ~bit_end) begin
        cnt_q <= cnt_q - 16'd1;
      end else begin
        cnt_q <= fdiv_q - 16'd1;
        unique case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
          end
          S_START: begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
          S_DATA: begin
            if (idx_q == last_idx) begin
`ifdef UART_TX_PARITY_EN
              if (has_par) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
`endif
          S_STOP: begin
            if (last_stop) begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              cnt_q   <= '0;
            end else begin
              stop2_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TX       = tx_q;
  assign BUSY     = busy_q;
  assign FULL     = full;
  assign OVERFLOW = ovf_q;
  assign TX_DONE  = done_q;

endmodule
